// File: rtl/vend_price_engine.sv
// vend_price_engine: run-time programmable N-entry price table plus the
// vending transaction engine (coin credit, selection check, dispense pulse,
// change return over a valid/ack handshake).
// Optional build macro: VEND_TIMEOUT_EN enables the idle auto-refund counter
// in COLLECT; without it COLLECT waits indefinitely.
// All outputs are registers loaded with the value that belongs to the state
// being entered, so a state's outputs are visible for the whole cycle the
// engine spends in it.

module vend_price_engine #(
    parameter int NUM_ITEMS   = 8,
    parameter int SEL_W       = 3,
    parameter int PRICE_W     = 8,
    parameter int CREDIT_W    = 10,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_coin_valid,
    input  logic [PRICE_W-1:0]  i_coin_value,
    output logic                o_coin_ready,
    output logic                o_coin_reject,
    input  logic                i_sel_valid,
    input  logic [SEL_W-1:0]    i_item_sel,
    input  logic                i_cancel,
    input  logic                i_prog_we,
    input  logic [SEL_W-1:0]    i_prog_addr,
    input  logic [PRICE_W-1:0]  i_prog_price,
    output logic                o_prog_reject,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_dispense,
    output logic [SEL_W-1:0]    o_dispense_item,
    output logic                o_insufficient,
    output logic                o_change_valid,
    output logic [CREDIT_W-1:0] o_change_amount,
    input  logic                i_change_ack
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_VEND    = 3'd3;
    localparam logic [2:0] S_REFUND  = 3'd4;

    localparam logic [SEL_W:0] NUM_ITEMS_W = NUM_ITEMS[SEL_W:0];

    // Power-on price for table entry idx, truncated to the price width.
    function automatic logic [PRICE_W-1:0] f_default_price(input int idx);
        logic [15:0] v;
        case (idx)
            0:       v = 16'd125;
            1:       v = 16'd100;
            2:       v = 16'd85;
            3:       v = 16'd150;
            4:       v = 16'd225;
            5:       v = 16'd185;
            6:       v = 16'd50;
            7:       v = 16'd135;
            default: v = 16'd100;
        endcase
        return v[PRICE_W-1:0];
    endfunction

    logic [2:0]          r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [SEL_W-1:0]    r_sel;
    logic [PRICE_W-1:0]  r_price [NUM_ITEMS];
    logic                r_coin_ready;
    logic                r_coin_reject;
    logic                r_prog_reject;
    logic                r_dispense;
    logic [SEL_W-1:0]    r_dispense_item;
    logic                r_insufficient;
    logic                r_change_valid;
    logic [CREDIT_W-1:0] r_change_amount;

    logic [2:0]          w_state_nxt;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic                w_dispense_nxt;
    logic [SEL_W-1:0]    w_dispense_item_nxt;
    logic                w_insufficient_nxt;
    logic                w_change_valid_nxt;
    logic [CREDIT_W-1:0] w_change_amount_nxt;
    logic                w_coin_reject_nxt;
    logic                w_prog_reject_nxt;
    logic                w_prog_wr;
    logic                w_coin_ready_nxt;
    logic                w_timeout;

    logic                w_sel_ok;
    logic                w_addr_ok;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_credit_sat;
    logic [CREDIT_W-1:0] w_price_ext;

    assign w_sel_ok     = ({1'b0, i_item_sel} < NUM_ITEMS_W);
    assign w_addr_ok    = ({1'b0, i_prog_addr} < NUM_ITEMS_W);
    assign w_sum        = {1'b0, r_credit} + {{(CREDIT_W + 1 - PRICE_W){1'b0}}, i_coin_value};
    assign w_credit_sat = w_sum[CREDIT_W] ? {CREDIT_W{1'b1}} : w_sum[CREDIT_W-1:0];
    assign w_price_ext  = {{(CREDIT_W - PRICE_W){1'b0}}, r_price[r_sel]};

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] r_tmo;
    logic             w_tmo_clr;

    assign w_tmo_clr = i_coin_valid | (i_sel_valid & ~w_sel_ok);
    assign w_timeout = (r_state == S_COLLECT) && (r_tmo == TMO_W'(TIMEOUT_CYC));

    // Idle counter: counts only while staying in COLLECT with no activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= {TMO_W{1'b0}};
        end else if ((r_state == S_COLLECT) && (w_state_nxt == S_COLLECT) && !w_tmo_clr) begin
            r_tmo <= r_tmo + {{(TMO_W - 1){1'b0}}, 1'b1};
        end else begin
            r_tmo <= {TMO_W{1'b0}};
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and next-output decode for the transaction engine.
    always_comb begin
        w_state_nxt         = r_state;
        w_credit_nxt        = r_credit;
        w_sel_nxt           = r_sel;
        w_dispense_nxt      = 1'b0;
        w_dispense_item_nxt = r_dispense_item;
        w_insufficient_nxt  = 1'b0;
        w_change_valid_nxt  = r_change_valid;
        w_change_amount_nxt = r_change_amount;
        w_coin_reject_nxt   = i_coin_valid & ~r_coin_ready;
        w_prog_wr           = 1'b0;
        w_prog_reject_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A selection with no credit is always refused.
                w_insufficient_nxt = i_sel_valid;
                if (i_coin_valid) begin
                    w_credit_nxt = w_credit_sat;
                    w_state_nxt  = S_COLLECT;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            S_COLLECT: begin
                // A coin in the same cycle as cancel/select still counts.
                w_credit_nxt = i_coin_valid ? w_credit_sat : r_credit;
                if (i_cancel || w_timeout) begin
                    w_state_nxt         = S_REFUND;
                    w_change_valid_nxt  = 1'b1;
                    w_change_amount_nxt = w_credit_nxt;
                end else if (i_sel_valid) begin
                    if (w_sel_ok) begin
                        w_sel_nxt   = i_item_sel;
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_insufficient_nxt = 1'b1;
                        w_state_nxt        = S_COLLECT;
                    end
                end else begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_CHECK: begin
                if (r_credit >= w_price_ext) begin
                    w_credit_nxt        = r_credit - w_price_ext;
                    w_state_nxt         = S_VEND;
                    w_dispense_nxt      = 1'b1;
                    w_dispense_item_nxt = r_sel;
                end else begin
                    w_insufficient_nxt = 1'b1;
                    w_state_nxt        = S_COLLECT;
                end
            end
            S_VEND: begin
                if (r_credit != {CREDIT_W{1'b0}}) begin
                    w_state_nxt         = S_REFUND;
                    w_change_valid_nxt  = 1'b1;
                    w_change_amount_nxt = r_credit;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REFUND: begin
                if (i_change_ack) begin
                    w_credit_nxt        = {CREDIT_W{1'b0}};
                    w_change_valid_nxt  = 1'b0;
                    w_change_amount_nxt = {CREDIT_W{1'b0}};
                    w_state_nxt         = S_IDLE;
                end else begin
                    w_state_nxt = S_REFUND;
                end
            end
            default: begin
                w_state_nxt         = S_IDLE;
                w_credit_nxt        = {CREDIT_W{1'b0}};
                w_change_valid_nxt  = 1'b0;
                w_change_amount_nxt = {CREDIT_W{1'b0}};
            end
        endcase

        // Price writes only land while no transaction is in progress.
        if (i_prog_we) begin
            if ((r_state == S_IDLE) && w_addr_ok) begin
                w_prog_wr = 1'b1;
            end else begin
                w_prog_reject_nxt = 1'b1;
            end
        end else begin
            w_prog_wr         = 1'b0;
            w_prog_reject_nxt = 1'b0;
        end
    end

    assign w_coin_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_COLLECT);

    // Engine state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_credit        <= {CREDIT_W{1'b0}};
            r_sel           <= {SEL_W{1'b0}};
            r_coin_ready    <= 1'b1;
            r_coin_reject   <= 1'b0;
            r_prog_reject   <= 1'b0;
            r_dispense      <= 1'b0;
            r_dispense_item <= {SEL_W{1'b0}};
            r_insufficient  <= 1'b0;
            r_change_valid  <= 1'b0;
            r_change_amount <= {CREDIT_W{1'b0}};
        end else begin
            r_state         <= w_state_nxt;
            r_credit        <= w_credit_nxt;
            r_sel           <= w_sel_nxt;
            r_coin_ready    <= w_coin_ready_nxt;
            r_coin_reject   <= w_coin_reject_nxt;
            r_prog_reject   <= w_prog_reject_nxt;
            r_dispense      <= w_dispense_nxt;
            r_dispense_item <= w_dispense_item_nxt;
            r_insufficient  <= w_insufficient_nxt;
            r_change_valid  <= w_change_valid_nxt;
            r_change_amount <= w_change_amount_nxt;
        end
    end

    // Price table: power-on defaults, rewritten only by accepted writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                r_price[i] <= f_default_price(i);
            end
        end else if (w_prog_wr) begin
            r_price[i_prog_addr] <= i_prog_price;
        end
    end

    assign o_coin_ready    = r_coin_ready;
    assign o_coin_reject   = r_coin_reject;
    assign o_prog_reject   = r_prog_reject;
    assign o_credit        = r_credit;
    assign o_dispense      = r_dispense;
    assign o_dispense_item = r_dispense_item;
    assign o_insufficient  = r_insufficient;
    assign o_change_valid  = r_change_valid;
    assign o_change_amount = r_change_amount;

endmodule

// File: doc/vend_price_engine.md
Name: vend_price_engine

Overview:
- Parametrised successor to the fixed item price lookup: an N-entry price table that can be reprogrammed at run time, plus a vending transaction engine.
- Accumulates coin credit, checks the selected item's price against credit, pulses dispense, and returns change over a valid/ack handshake.
- Sits between the coin/keypad input synchronisers and the dispenser/display logic of the vending machine top level.

Parameters:
- NUM_ITEMS, 8, number of price table entries (2..256).
- SEL_W, 3, item select width; must equal $clog2(NUM_ITEMS).
- PRICE_W, 8, price and coin value width (cents).
- CREDIT_W, 10, credit accumulator width; must be greater than PRICE_W.
- TIMEOUT_CYC, 1000, idle cycles before auto-refund (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- coin_valid  in  1  one-cycle coin strobe.
- coin_value  in  PRICE_W  value of the coin.
- coin_ready  out  1  high when coins are accepted.
- coin_reject  out  1  one-cycle pulse when a coin arrives while coin_ready is low.
- sel_valid  in  1  one-cycle selection strobe.
- item_sel  in  SEL_W  selected item.
- cancel  in  1  one-cycle refund request.
- prog_we  in  1  price write strobe.
- prog_addr  in  SEL_W  price entry to write.
- prog_price  in  PRICE_W  new price.
- prog_reject  out  1  one-cycle pulse when a write is refused.
- credit  out  CREDIT_W  current credit.
- dispense  out  1  one-cycle vend pulse.
- dispense_item  out  SEL_W  item vended; valid while dispense is high.
- insufficient  out  1  one-cycle pulse: selection refused.
- change_valid  out  1  change pending.
- change_amount  out  CREDIT_W  change value; stable while change_valid is high.
- change_ack  in  1  change accepted.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; credit = 0; all pulse outputs = 0; change_valid = 0; change_amount = 0; coin_ready = 1.
  - Price table entries 0..7 = 125, 100, 85, 150, 225, 185, 50, 135. Entries 8 and above = 100. Each value is truncated to PRICE_W.
  - Reset mid-transaction discards credit with no refund and no dispense.
- Outputs: all registered. coin_ready = 1 in IDLE and COLLECT only.
- FSM states: IDLE, COLLECT, CHECK, VEND, REFUND.
- IDLE:
  - coin_valid: credit += coin_value, go to COLLECT.
  - sel_valid: insufficient pulse; stay in IDLE.
  - cancel: ignored.
- COLLECT:
  - coin_valid: credit += coin_value, saturating at 2^CREDIT_W-1.
  - cancel has priority over sel_valid: go to REFUND.
  - sel_valid: latch item_sel and go to CHECK. A coin arriving in the same cycle is added before the check.
  - item_sel >= NUM_ITEMS: insufficient pulse, latch nothing, stay in COLLECT.
- CHECK (1 cycle):
  - If credit >= price[sel]: credit -= price[sel], go to VEND.
  - Otherwise: insufficient pulse, return to COLLECT with credit unchanged.
- VEND (1 cycle):
  - dispense = 1 and dispense_item = latched sel.
  - Next state is REFUND if credit > 0, else IDLE.
- REFUND:
  - change_valid = 1 and change_amount = credit, held until change_ack is sampled high.
  - On that edge: credit = 0, change_valid = 0, go to IDLE.
  - change_ack while change_valid is low is ignored.
- Latency: sel_valid sampled at edge N; CHECK occupies cycle N+1; dispense or insufficient is high in cycle N+2; change_valid is high from cycle N+3.
- Coins arriving in CHECK, VEND or REFUND are dropped and produce a coin_reject pulse.
- Price programming:
  - prog_we is honoured only in IDLE; the new value is visible from the next cycle.
  - In any other state the write is dropped and prog_reject pulses.
  - prog_addr >= NUM_ITEMS is dropped with a prog_reject pulse.
- Arithmetic: price is zero-extended to CREDIT_W. The subtraction never underflows because it is guarded by the compare.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) runs in COLLECT.
  - It clears on any accepted coin or on a selection that is refused.
  - On reaching TIMEOUT_CYC it forces REFUND, exactly as a cancel would.
  - The counter is held at 0 outside COLLECT.
- Undefined: no counter; COLLECT waits indefinitely.

Test Plan:
- Reset, then coins 100 and 25, then select item 0 → dispense with item 0 in cycle N+2; credit = 0; no change_valid; return to IDLE.
- Coin 100, select item 4 (price 225) → insufficient pulse, credit stays 100; then coin 200, select 4 → dispense; change_valid with change_amount 75, held until change_ack, then credit = 0.
- Coin 50 and cancel in the same cycle as sel_valid for item 6 → REFUND with change_amount 50; no dispense.
- In IDLE, write 40 to address 2, then coin 50, select 2 → dispense, change 10. A write attempted in COLLECT → prog_reject; price unchanged.
- Coin during REFUND → coin_reject, credit unchanged. Assert rst_n low during REFUND → change_valid 0 and credit 0 immediately.
- With VEND_TIMEOUT_EN and TIMEOUT_CYC = 20: coin 25, then idle → change_valid rises 21 cycles after the coin with change_amount 25. Without the macro: no change after 100 cycles.
